// File: rtl/cms_multi_range_tracer.sv
// Purpose: filtered retire-port trace capture {pc, instr} into a FWFT buffer, drained over AXI-Stream.
// Latency: candidate written at the retire edge, M_AXIS_tvalid rises one cycle later.
// Backpressure: tready low holds the head beat; a full buffer drops new candidates and counts them.
module cms_multi_range_tracer #(
    parameter int          XLEN                                = 64,
    parameter int          NUM_RANGES                          = 4,
    parameter int          FIFO_DEPTH                          = 16,
    parameter logic [31:0] WFI_INSTR                           = 32'h10500073,
    parameter bit          CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr,
    input  logic [XLEN-1:0]    pc,
    input  logic               pc_valid,
    output logic               M_AXIS_tvalid,
    input  logic               M_AXIS_tready,
    output logic [XLEN+31:0]   M_AXIS_tdata,
    output logic               M_AXIS_tlast,
    input  logic [31:0]        tlast_interval,
    input  logic [7:0]         ctrl_addr,
    input  logic [63:0]        ctrl_wdata,
    input  logic               ctrl_write_enable,
    output logic [1:0]         state,
    output logic [31:0]        drop_count,
    output logic               wfi_dropped
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = XLEN + 33;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_START, S_TRACING, S_STOPPED} state_t;

    // ---------------- control write strobe ----------------
    logic        we_q, we_qq;
    logic [7:0]  addr_q;
    logic [63:0] wdata_q;
    logic        wr_fire;
    logic [7:0]  wr_addr;
    logic [63:0] wr_data;
    logic        ctrl_sel;

    // Delay strobe/address/data so a rising edge fires one cycle after it is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            we_qq   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= ctrl_write_enable;
            we_qq   <= we_q;
            addr_q  <= ctrl_addr;
            wdata_q <= ctrl_wdata;
        end
    end

    assign wr_fire  = CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED ? (we_q & ~we_qq) : ctrl_write_enable;
    assign wr_addr  = CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED ? addr_q  : ctrl_addr;
    assign wr_data  = CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED ? wdata_q : ctrl_wdata;
    assign ctrl_sel = wr_fire && (wr_addr == 8'h00);

    // ---------------- configuration registers ----------------
    logic [1:0]      trig_cfg;
    logic [XLEN-1:0] start_addr, stop_addr;
    logic [XLEN-1:0] rng_lo [NUM_RANGES];
    logic [XLEN-1:0] rng_hi [NUM_RANGES];
    logic [2:0]      rng_cfg [NUM_RANGES];

    // Register file writes; unmapped addresses fall through untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_cfg   <= '0;
            start_addr <= '0;
            stop_addr  <= '0;
            for (int i = 0; i < NUM_RANGES; i++) begin
                rng_lo[i]  <= '0;
                rng_hi[i]  <= '1;
                rng_cfg[i] <= '0;
            end
        end else if (wr_fire) begin
            if (wr_addr == 8'h01) trig_cfg   <= wr_data[1:0];
            if (wr_addr == 8'h02) start_addr <= wr_data[XLEN-1:0];
            if (wr_addr == 8'h03) stop_addr  <= wr_data[XLEN-1:0];
            for (int i = 0; i < NUM_RANGES; i++) begin
                if (wr_addr == 8'(16 + 4 * i)) rng_lo[i]  <= wr_data[XLEN-1:0];
                if (wr_addr == 8'(17 + 4 * i)) rng_hi[i]  <= wr_data[XLEN-1:0];
                if (wr_addr == 8'(18 + 4 * i)) rng_cfg[i] <= wr_data[2:0];
            end
        end
    end

    // ---------------- range filter ----------------
    logic [NUM_RANGES-1:0] rng_act, rng_hit, rng_exc;
    logic                  pass;

    // A range with a disabled bound is open on that side; lo>hi can never hit.
    always_comb begin
        rng_act = '0;
        rng_hit = '0;
        rng_exc = '0;
        for (int i = 0; i < NUM_RANGES; i++) begin
            rng_act[i] = rng_cfg[i][0] | rng_cfg[i][1];
            rng_exc[i] = rng_cfg[i][2];
            rng_hit[i] = rng_act[i]
                       & (~rng_cfg[i][0] | (pc >= rng_lo[i]))
                       & (~rng_cfg[i][1] | (pc <= rng_hi[i]));
        end
        pass = (~|(rng_act & ~rng_exc) | |(rng_hit & ~rng_exc)) & ~|(rng_hit & rng_exc);
    end

    // ---------------- trigger state machine ----------------
    state_t state_q, state_d;
    logic   start_hit, wfi_hit;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Control writes win over trigger matches in the same cycle.
    always_comb begin
        state_d   = state_q;
        start_hit = 1'b0;
        wfi_hit   = 1'b0;
        if (wr_fire) begin
            if (ctrl_sel) begin
                if (!wr_data[0])
                    state_d = S_IDLE;
                else if (state_q == S_IDLE || state_q == S_STOPPED)
                    state_d = trig_cfg[0] ? S_WAIT_START : S_TRACING;
            end
        end else if (pc_valid) begin
            case (state_q)
                S_WAIT_START: begin
                    if (pc == start_addr) begin
                        start_hit = 1'b1;
                        state_d   = S_TRACING;
                    end
                end
                S_TRACING: begin
                    if (instr == WFI_INSTR) begin
                        wfi_hit = 1'b1;
                        state_d = S_STOPPED;
                    end else if (trig_cfg[1] && pc == stop_addr) begin
                        state_d = S_STOPPED;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

    // ---------------- capture buffer ----------------
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [31:0]   beat_cnt;
    logic          empty, full, cand, push, pop, drop, beat_last;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cand      = pc_valid & pass & ((state_q == S_TRACING) | start_hit);
    assign push      = cand & ~full;
    assign drop      = cand & full;
    assign pop       = ~empty & M_AXIS_tready;
    assign beat_last = wfi_hit | ((tlast_interval != 32'd0) && (beat_cnt == tlast_interval - 32'd1));

    // Entry storage; contents are don't-care until the write pointer covers them.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {pc, instr, beat_last};
    end

    // Pointers, beat counter and drop accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            beat_cnt    <= '0;
            drop_count  <= '0;
            wfi_dropped <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                beat_cnt <= beat_last ? 32'd0 : beat_cnt + 32'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (ctrl_sel && wr_data[1]) begin
                drop_count  <= '0;
                wfi_dropped <= 1'b0;
            end else if (drop) begin
                if (drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
                if (wfi_hit) wfi_dropped <= 1'b1;
            end
        end
    end

    assign M_AXIS_tvalid = ~empty;
    assign M_AXIS_tdata  = mem[rd_ptr[AW-1:0]][DW-1:1];
    assign M_AXIS_tlast  = ~empty & mem[rd_ptr[AW-1:0]][0];

endmodule

// File: tb/tb_cms_multi_range_tracer.sv
// Directed bench for cms_multi_range_tracer: triggers, range filtering, overflow,
// stalls and mid-stream reset, each step checked against hand-computed values.
module tb_cms_multi_range_tracer;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] WFI = 32'h1050_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        pc_valid;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tready;
    logic [95:0] M_AXIS_tdata;
    logic        M_AXIS_tlast;
    logic [31:0] tlast_interval;
    logic [7:0]  ctrl_addr;
    logic [63:0] ctrl_wdata;
    logic        ctrl_write_enable;
    logic [1:0]  state;
    logic [31:0] drop_count;
    logic        wfi_dropped;

    always #5 clk = ~clk;

    cms_multi_range_tracer dut (
        .clk               (clk),
        .rst               (rst),
        .instr             (instr),
        .pc                (pc),
        .pc_valid          (pc_valid),
        .M_AXIS_tvalid     (M_AXIS_tvalid),
        .M_AXIS_tready     (M_AXIS_tready),
        .M_AXIS_tdata      (M_AXIS_tdata),
        .M_AXIS_tlast      (M_AXIS_tlast),
        .tlast_interval    (tlast_interval),
        .ctrl_addr         (ctrl_addr),
        .ctrl_wdata        (ctrl_wdata),
        .ctrl_write_enable (ctrl_write_enable),
        .state             (state),
        .drop_count        (drop_count),
        .wfi_dropped       (wfi_dropped)
    );

    // Accepted beats, captured mid-cycle where inputs and outputs are settled.
    logic [96:0] got[$];
    always @(negedge clk) begin
        if (!rst && M_AXIS_tvalid && M_AXIS_tready)
            got.push_back({M_AXIS_tdata, M_AXIS_tlast});
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [63:0] d);
        ctrl_addr         = a;
        ctrl_wdata        = d;
        ctrl_write_enable = 1'b1;
        tick();
        ctrl_write_enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic pkt(input logic [63:0] p, input logic [31:0] ins);
        pc       = p;
        instr    = ins;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
    endtask

    function automatic logic [96:0] beat(input logic [63:0] p, input logic [31:0] ins, input logic l);
        return {p, ins, l};
    endfunction

    function automatic logic [96:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return '1;
    endfunction

    logic [95:0] prev_d;
    logic        prev_v;
    logic        prev_r;

    initial begin
        rst = 1'b1; instr = NOP; pc = '0; pc_valid = 1'b0; M_AXIS_tready = 1'b0;
        tlast_interval = 32'd0; ctrl_addr = '0; ctrl_wdata = '0; ctrl_write_enable = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_tvalid", M_AXIS_tvalid, 1'b0);
        check("rst_tlast", M_AXIS_tlast, 1'b0);
        check("rst_state", state, 2'd0);
        check("rst_drop", drop_count, 32'd0);
        check("rst_wfi", wfi_dropped, 1'b0);
        rst = 1'b0;
        tick();

        // Plain arm, interval tlast plus forced WFI tlast
        M_AXIS_tready  = 1'b1;
        tlast_interval = 32'd4;
        wr(8'h00, 64'h1);
        check("t1_state_arm", state, 2'd2);
        for (int k = 0; k < 5; k++)
            pkt(64'h1000 + 64'(4 * k), (k == 4) ? WFI : NOP);
        tick(); tick(); tick();
        check("t1_count", got.size(), 5);
        check("t1_b0", got_at(0), beat(64'h1000, NOP, 1'b0));
        check("t1_b1", got_at(1), beat(64'h1004, NOP, 1'b0));
        check("t1_b2", got_at(2), beat(64'h1008, NOP, 1'b0));
        check("t1_b3", got_at(3), beat(64'h100C, NOP, 1'b1));
        check("t1_b4", got_at(4), beat(64'h1010, WFI, 1'b1));
        check("t1_state_end", state, 2'd3);

        // Start/stop triggers
        got.delete();
        tlast_interval = 32'd0;
        wr(8'h01, 64'h3);
        wr(8'h02, 64'h2000);
        wr(8'h03, 64'h2008);
        wr(8'h00, 64'h1);
        check("t2_state_wait", state, 2'd1);
        pkt(64'h1FFC, NOP);
        check("t2_state_still_wait", state, 2'd1);
        pkt(64'h2000, NOP);
        pkt(64'h2004, NOP);
        pkt(64'h2008, NOP);
        pkt(64'h200C, NOP);
        tick(); tick(); tick();
        check("t2_count", got.size(), 3);
        check("t2_b0", got_at(0), beat(64'h2000, NOP, 1'b0));
        check("t2_b1", got_at(1), beat(64'h2004, NOP, 1'b0));
        check("t2_b2", got_at(2), beat(64'h2008, NOP, 1'b0));
        check("t2_state_end", state, 2'd3);

        // Include range with an exclude hole
        got.delete();
        wr(8'h01, 64'h0);
        wr(8'h10, 64'h100);
        wr(8'h11, 64'h1FF);
        wr(8'h12, 64'h3);
        wr(8'h14, 64'h180);
        wr(8'h15, 64'h18F);
        wr(8'h16, 64'h7);
        wr(8'h00, 64'h1);
        check("t3_state", state, 2'd2);
        pkt(64'h0FF, NOP);
        pkt(64'h100, NOP);
        pkt(64'h184, NOP);
        pkt(64'h1FF, NOP);
        pkt(64'h200, NOP);
        tick(); tick(); tick();
        check("t3_count", got.size(), 2);
        check("t3_b0", got_at(0), beat(64'h100, NOP, 1'b0));
        check("t3_b1", got_at(1), beat(64'h1FF, NOP, 1'b0));

        // Overflow: 20 candidates into 16 entries, WFI among the dropped
        got.delete();
        M_AXIS_tready = 1'b0;
        for (int k = 0; k < 20; k++)
            pkt(64'h100 + 64'(4 * k), (k == 19) ? WFI : NOP);
        check("t4_drop", drop_count, 32'd4);
        check("t4_wfi_dropped", wfi_dropped, 1'b1);
        check("t4_state", state, 2'd3);
        check("t4_tvalid", M_AXIS_tvalid, 1'b1);
        check("t4_head", {M_AXIS_tdata, M_AXIS_tlast}, beat(64'h100, NOP, 1'b0));
        M_AXIS_tready = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        check("t4_count", got.size(), 16);
        for (int k = 0; k < 16; k++)
            check($sformatf("t4_b%0d", k), got_at(k), beat(64'h100 + 64'(4 * k), NOP, 1'b0));
        check("t4_empty", M_AXIS_tvalid, 1'b0);
        check("t4_wfi_sticky", wfi_dropped, 1'b1);

        // Disarm together with clearing the drop statistics
        wr(8'h00, 64'h2);
        check("clr_state", state, 2'd0);
        check("clr_drop", drop_count, 32'd0);
        check("clr_wfi", wfi_dropped, 1'b0);

        // Stalled stream with tready toggling 1010...
        got.delete();
        wr(8'h00, 64'h1);
        M_AXIS_tready = 1'b0;
        for (int k = 0; k < 8; k++)
            pkt(64'h100 + 64'(4 * k), NOP);
        check("t5_none_yet", got.size(), 0);
        for (int i = 0; i < 16; i++) begin
            M_AXIS_tready = (i % 2 == 0);
            prev_d = M_AXIS_tdata;
            prev_v = M_AXIS_tvalid;
            prev_r = M_AXIS_tready;
            tick();
            if (prev_v && !prev_r)
                check($sformatf("t5_hold%0d", i), M_AXIS_tdata, prev_d);
        end
        M_AXIS_tready = 1'b1;
        tick(); tick();
        check("t5_count", got.size(), 8);
        for (int k = 0; k < 8; k++)
            check($sformatf("t5_b%0d", k), got_at(k), beat(64'h100 + 64'(4 * k), NOP, 1'b0));

        // Reset with 6 beats still buffered mid-transfer
        got.delete();
        M_AXIS_tready = 1'b0;
        for (int k = 0; k < 18; k++)
            pkt(64'h100 + 64'(4 * k), NOP);
        check("t6_drop_pre", drop_count, 32'd2);
        M_AXIS_tready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("t6_drained", got.size(), 10);
        check("t6_tvalid_pre", M_AXIS_tvalid, 1'b1);
        rst = 1'b1;
        tick();
        check("t6_tvalid", M_AXIS_tvalid, 1'b0);
        check("t6_tlast", M_AXIS_tlast, 1'b0);
        check("t6_drop", drop_count, 32'd0);
        check("t6_state", state, 2'd0);
        rst = 1'b0;
        tick(); tick();
        check("t6_stays_empty", M_AXIS_tvalid, 1'b0);
        got.delete();
        tlast_interval = 32'd3;
        wr(8'h00, 64'h1);
        check("t6_state_arm", state, 2'd2);
        pkt(64'h0FF, NOP);
        pkt(64'h184, NOP);
        pkt(64'h5000, NOP);
        tick(); tick(); tick();
        check("t6_count", got.size(), 3);
        check("t6_b0", got_at(0), beat(64'h0FF, NOP, 1'b0));
        check("t6_b1", got_at(1), beat(64'h184, NOP, 1'b0));
        check("t6_b2", got_at(2), beat(64'h5000, NOP, 1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
